// File: rtl/peripheral_ahb3_sram_slave.sv
// Purpose: AHB3-Lite slave that backs accepted transfers with a word-organised on-chip SRAM.
// Latency: OKAY transfers take WAIT_STATES+1 data cycles; illegal transfers take a fixed 2-cycle ERROR.
// Backpressure: HREADYOUT is low during wait states and ERR1; an address phase is accepted only when HREADY is high.
// Ports: HCLK/HRESETn are the clock and the async active-low reset.
//   HSEL/HADDR/HWRITE/HSIZE/HTRANS/HREADY form the address phase; HWDATA carries data-phase write data.
//   HRDATA/HREADYOUT/HRESP form the response; HBURST/HPROT/HMASTLOCK are accepted but ignored.
module peripheral_ahb3_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int NB       = HDATA_SIZE / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic [NB-1:0]         be_q, be_d;
  logic                  write_q;
  logic                  hreadyout_q, hresp_q;

  logic                  accept, illegal, misaligned;
  logic [HADDR_SIZE-1:0] word_addr;
  int                    off;

  // Only states that present HREADYOUT = 1 can take a new address phase.
  assign accept    = HSEL & HREADY & HTRANS[1] &
                     ((state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2));
  assign word_addr = HADDR >> ADDR_LSB;
  assign illegal   = (word_addr >= HADDR_SIZE'(MEM_DEPTH)) | (HSIZE > 3'(ADDR_LSB)) | misaligned;

  // Byte lanes covered by the transfer, plus alignment of HADDR to the transfer size.
  always_comb begin
    misaligned = 1'b0;
    be_d       = '0;
    off        = int'(HADDR[ADDR_LSB-1:0]);
    for (int i = 0; i < ADDR_LSB; i++) begin
      if ((i < int'(HSIZE)) && HADDR[i]) misaligned = 1'b1;
    end
    for (int b = 0; b < NB; b++) begin
      be_d[b] = (b >= off) && (b < off + (1 << HSIZE));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (accept) begin
          if (illegal)                state_d = ST_ERR1;
          else if (WAIT_STATES == 0)  state_d = ST_DATA;
          else begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Response flags are registered from the next state so they change only on the clock.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      be_q        <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= word_addr[IDX_W-1:0];
        be_q    <= be_d;
        write_q <= HWRITE;
      end
      hreadyout_q <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
      hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end
  end

  // Writes commit at the edge closing the DATA cycle. Reset forces IDLE at once,
  // so an interrupted write never reaches this point.
  always_ff @(posedge HCLK) begin
    if ((state_q == ST_DATA) && write_q) begin
      for (int b = 0; b < NB; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Read data is taken straight from the array during the DATA cycle, so a write
  // committed on the edge that opens this cycle is already visible.
  assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem[idx_q] : '0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

endmodule

// File: tb/tb_peripheral_ahb3_sram_slave.sv
// Purpose: self-checking bench for peripheral_ahb3_sram_slave on two instances (0 and 3 wait states).
// Latency: a cycle-level expectation queue per instance is compared against the outputs every cycle.
// Backpressure: HREADY is looped back from HREADYOUT, optionally forced low to mimic another slave stalling.
module tb_peripheral_ahb3_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn      [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [1:0]  htrans    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic        stall     [2];

  int checks = 0;
  int errors = 0;

  assign hready[0] = hreadyout[0] & ~stall[0];
  assign hready[1] = hreadyout[1] & ~stall[1];

  peripheral_ahb3_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rstn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
    .HRDATA(hrdata[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'b000), .HPROT(4'b0011),
    .HTRANS(htrans[0]), .HMASTLOCK(1'b0), .HREADY(hready[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
  );

  peripheral_ahb3_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESETn(rstn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
    .HRDATA(hrdata[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'b000), .HPROT(4'b0011),
    .HTRANS(htrans[1]), .HMASTLOCK(1'b0), .HREADY(hready[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, exp);
    end
  endtask

  // One expected response cycle: what the slave must show while that cycle lasts.
  typedef struct packed {
    logic       rdy;
    logic       resp;
    logic       data;
    logic       wr;
    logic [7:0] idx;
    logic [3:0] be;
  } cyc_t;

  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int W = (g == 0) ? 0 : 3;
    cyc_t        q [$];
    logic [31:0] mm [256];

    always @(negedge clk) begin : cmp
      cyc_t        cur;
      logic [31:0] exp_rd;
      int          off;
      bit          bad;
      if (!rstn[g]) begin
        q.delete();
        chk("reset hreadyout", 32'(hreadyout[g]), 32'd1);
        chk("reset hresp", 32'(hresp[g]), 32'd0);
        chk("reset hrdata", hrdata[g], 32'd0);
      end else begin
        if (q.size() > 0) cur = q.pop_front();
        else cur = '{rdy: 1'b1, resp: 1'b0, data: 1'b0, wr: 1'b0, idx: 8'd0, be: 4'd0};
        exp_rd = (cur.data && !cur.wr) ? mm[cur.idx] : 32'd0;
        chk("hreadyout", 32'(hreadyout[g]), 32'(cur.rdy));
        chk("hresp", 32'(hresp[g]), 32'(cur.resp));
        chk("hrdata", hrdata[g], exp_rd);
        // Data phase of a write: HWDATA is stable here and is what the closing edge samples.
        if (cur.data && cur.wr) begin
          for (int k = 0; k < 4; k++) if (cur.be[k]) mm[cur.idx][8*k +: 8] = hwdata[g][8*k +: 8];
        end
        if (hsel[g] && cur.rdy && !stall[g] && htrans[g][1]) begin
          bad = ((haddr[g] >> 2) >= 32'd256) || (hsize[g] > 3'd2) ||
                ((haddr[g] % (32'd1 << hsize[g])) != 32'd0);
          if (bad) begin
            q.push_back('{rdy: 1'b0, resp: 1'b1, data: 1'b0, wr: 1'b0, idx: 8'd0, be: 4'd0});
            q.push_back('{rdy: 1'b1, resp: 1'b1, data: 1'b0, wr: 1'b0, idx: 8'd0, be: 4'd0});
          end else begin
            cur = '{rdy: 1'b1, resp: 1'b0, data: 1'b1, wr: hwrite[g], idx: haddr[g][9:2], be: 4'd0};
            off = int'(haddr[g][1:0]);
            for (int k = 0; k < 4; k++) cur.be[k] = (k >= off) && (k < off + (1 << hsize[g]));
            repeat (W) q.push_back('{rdy: 1'b0, resp: 1'b0, data: 1'b0, wr: 1'b0, idx: 8'd0, be: 4'd0});
            q.push_back(cur);
          end
        end
      end
    end
  end

  task automatic go_idle(input int b);
    hsel[b]   = 1'b0;
    htrans[b] = 2'b00;
  endtask

  // Drive an address phase, hold it until HREADY accepts it, then drive its data-phase HWDATA.
  task automatic xfer(input int b, input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    hsel[b] = sel; htrans[b] = tr; hwrite[b] = wr; hsize[b] = sz; haddr[b] = a;
    n = 0;
    @(negedge clk);
    while (!hready[b] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!hready[b]) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout bus %0d: hready %b after %0d cycles, required 1", b, hready[b], n);
    end
    @(posedge clk);
    #1;
    hwdata[b] = wd;
  endtask

  task automatic read_expect(input int b, input logic [31:0] a, input logic [31:0] exp, input int ws);
    int n;
    xfer(b, 1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0);
    go_idle(b);
    n = 0;
    @(negedge clk);
    while (!hreadyout[b] && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("read wait cycles", 32'(n), 32'(ws));
    chk("read data", hrdata[b], exp);
    chk("read hresp", 32'(hresp[b]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic err_expect(input int b, input logic wr, input logic [2:0] sz, input logic [31:0] a);
    xfer(b, 1'b1, 2'b10, wr, sz, a, 32'hFFFF_FFFF);
    go_idle(b);
    @(negedge clk);
    chk("err1 hreadyout", 32'(hreadyout[b]), 32'd0);
    chk("err1 hresp", 32'(hresp[b]), 32'd1);
    @(negedge clk);
    chk("err2 hreadyout", 32'(hreadyout[b]), 32'd1);
    chk("err2 hresp", 32'(hresp[b]), 32'd1);
    chk("err2 hrdata", hrdata[b], 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int b = 0; b < 2; b++) begin
      rstn[b] = 1'b0; hsel[b] = 1'b0; haddr[b] = '0; hwdata[b] = '0;
      hwrite[b] = 1'b0; hsize[b] = 3'd0; htrans[b] = 2'b00; stall[b] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("por hreadyout dut0", 32'(hreadyout[0]), 32'd1);
    chk("por hreadyout dut3", 32'(hreadyout[1]), 32'd1);
    @(posedge clk);
    #1;
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    // Give the first 16 words a known image on both instances.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) xfer(b, 1'b1, 2'b10, 1'b1, 3'd2, 32'(i * 4), 32'hA500_0000 | 32'(i));
      go_idle(b);
      repeat (6) @(posedge clk);
      #1;
    end

    // Zero wait states: back-to-back write then read.
    xfer(0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    read_expect(0, 32'h10, 32'hDEAD_BEEF, 0);

    // Byte lanes.
    xfer(0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h1122_3344);
    xfer(0, 1'b1, 2'b10, 1'b1, 3'd0, 32'h21, 32'h0000_AA00);
    xfer(0, 1'b1, 2'b10, 1'b1, 3'd1, 32'h22, 32'hBBBB_0000);
    read_expect(0, 32'h20, 32'hBBBB_AA44, 0);
    chk("model byte lanes", g_model[0].mm[8], 32'hBBBB_AA44);

    // Illegal transfers.
    err_expect(0, 1'b0, 3'd2, 32'h400);
    err_expect(0, 1'b0, 3'd1, 32'h01);
    err_expect(0, 1'b0, 3'd3, 32'h00);
    err_expect(0, 1'b1, 3'd2, 32'h01);
    read_expect(0, 32'h00, 32'hA500_0000, 0);

    // BUSY and unselected transfers between legal writes.
    xfer(0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h24, 32'h1234_5678);
    xfer(0, 1'b1, 2'b01, 1'b1, 3'd2, 32'h24, 32'hFFFF_FFFF);
    xfer(0, 1'b0, 2'b10, 1'b1, 3'd2, 32'h24, 32'hEEEE_EEEE);
    xfer(0, 1'b1, 2'b11, 1'b1, 3'd2, 32'h28, 32'h0BAD_F00D);
    go_idle(0);
    read_expect(0, 32'h24, 32'h1234_5678, 0);

    // Another slave holds HREADY low while a write is presented: no accept.
    hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; hsize[0] = 3'd2; haddr[0] = 32'h28;
    hwdata[0] = 32'hFFFF_FFFF; stall[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    go_idle(0);
    stall[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    read_expect(0, 32'h28, 32'h0BAD_F00D, 0);

    // Three wait states.
    read_expect(1, 32'h08, 32'hA500_0002, 3);
    xfer(1, 1'b1, 2'b10, 1'b1, 3'd2, 32'h0C, 32'hCAFE_F00D);
    read_expect(1, 32'h0C, 32'hCAFE_F00D, 3);
    err_expect(1, 1'b0, 3'd2, 32'h400);

    // Reset during the wait states of a write.
    xfer(1, 1'b1, 2'b10, 1'b1, 3'd2, 32'h30, 32'h0000_0005);
    xfer(1, 1'b1, 2'b10, 1'b1, 3'd2, 32'h30, 32'h0000_0077);
    go_idle(1);
    #2;
    rstn[1] = 1'b0;
    #1;
    chk("async reset hreadyout", 32'(hreadyout[1]), 32'd1);
    chk("async reset hresp", 32'(hresp[1]), 32'd0);
    chk("async reset hrdata", hrdata[1], 32'd0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rstn[1] = 1'b1;
    @(posedge clk);
    #1;
    read_expect(1, 32'h30, 32'h0000_0005, 3);

    // Randomised traffic checked cycle by cycle against the model.
    for (int b = 0; b < 2; b++) begin
      repeat (250) begin
        r = int'($urandom_range(0, 15));
        xfer(b, (r != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             (r == 1) ? 3'd3 : 3'($urandom_range(0, 2)),
             (r == 2) ? (32'h400 + 32'($urandom_range(0, 15)) * 4) : 32'($urandom_range(0, 63)),
             $urandom);
      end
      go_idle(b);
      repeat (8) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
